// File: rtl/load_extend_pipe.sv
// rtl/load_extend_pipe.sv - two-stage load-data aligner and zero/sign extender
module load_extend_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5,
    parameter int BIG_ENDIAN = 1,
    parameter int OFF_W      = $clog2(DATA_WIDTH / 8)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic [OFF_W-1:0]      in_off,
    input  logic [1:0]            in_size,
    input  logic                  in_signed,
    input  logic [TAG_WIDTH-1:0]  in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [TAG_WIDTH-1:0]  out_tag,
    output logic                  out_err,
    output logic [15:0]           err_count
);

    localparam int NB      = DATA_WIDTH / 8;
    localparam int TOP_MSB = (DATA_WIDTH >= 64) ? 63 : DATA_WIDTH - 1;

    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_field;
    logic [1:0]            s1_size;
    logic                  s1_signed;
    logic                  s1_err;
    logic [TAG_WIDTH-1:0]  s1_tag;

    logic                  s2_free;
    logic                  accept;
    logic                  advance;

    int                    sel_nbytes;
    int                    sel_off;
    int                    sel_shamt;
    logic [DATA_WIDTH-1:0] sel_field;
    logic                  sel_err;

    int                    ext_bits;
    logic                  ext_msb;
    logic [DATA_WIDTH-1:0] ext_data;

    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;
    assign accept   = in_valid && in_ready;
    assign advance  = s1_valid && s2_free;

    // Big-endian fields sit mirrored: the field LSB byte is byte NB-off-n in little-endian order.
    always_comb begin
        sel_nbytes = 1 << in_size;
        sel_off    = int'(in_off);
        sel_err    = ((8 * sel_nbytes) > DATA_WIDTH) || ((sel_off & (sel_nbytes - 1)) != 0);
        if (BIG_ENDIAN != 0) begin
            sel_shamt = (NB - sel_off - sel_nbytes) * 8;
        end else begin
            sel_shamt = sel_off * 8;
        end
        if (sel_shamt < 0) begin
            sel_shamt = 0;
        end
        sel_field = in_data >> sel_shamt;
    end

    always_comb begin
        ext_bits = 8 << s1_size;
        case (s1_size)
            2'd0:    ext_msb = s1_field[7];
            2'd1:    ext_msb = s1_field[15];
            2'd2:    ext_msb = s1_field[31];
            default: ext_msb = s1_field[TOP_MSB];
        endcase
        for (int i = 0; i < DATA_WIDTH; i++) begin
            ext_data[i] = (i < ext_bits) ? s1_field[i] : (s1_signed & ext_msb);
        end
        if (s1_err) begin
            ext_data = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_field  <= '0;
            s1_size   <= 2'd0;
            s1_signed <= 1'b0;
            s1_err    <= 1'b0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_tag   <= '0;
            out_err   <= 1'b0;
            err_count <= 16'd0;
        end else begin
            if (accept) begin
                s1_valid  <= 1'b1;
                s1_field  <= sel_field;
                s1_size   <= in_size;
                s1_signed <= in_signed;
                s1_err    <= sel_err;
                s1_tag    <= in_tag;
            end else if (advance) begin
                s1_valid <= 1'b0;
            end

            // Output payload only loads when stage 2 is free, so a stalled beat holds still.
            if (advance) begin
                out_valid <= 1'b1;
                out_data  <= ext_data;
                out_tag   <= s1_tag;
                out_err   <= s1_err;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (out_valid && out_ready && out_err && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

endmodule
